edge_trap_bank: RTL and testbench
=================================

Name: edge_trap_bank

Overview:
- Multi-channel successor to the single-bit asynchronous edge trap.
- Captures rising, falling or both edges on N_CH asynchronous inputs using per-channel toggle flops clocked by the async signal itself, so arbitrarily narrow pulses are caught.
- Each captured edge is carried into the clk domain through a SYNC_STAGES-deep synchroniser and reported three ways: a one-cycle pulse, a sticky pending flag with acknowledge, and a saturating event counter.
- Sits between external asynchronous event sources (buttons, sensor strobes) and the clk-domain control FSMs.

Parameters:
N_CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per toggle path (>=2)
CNT_W, 8, width of each per-channel event counter (>=2)

Ports:
clk  input  1  system clock; all outputs are clk-domain
reset  input  1  asynchronous, active-high; clears all state
async_sig  input  N_CH  asynchronous event inputs, one bit per channel
edge_mode  input  2*N_CH  per-channel mode, bits [2i+1:2i] for channel i: 00 off, 01 rising, 10 falling, 11 both
ack  input  N_CH  clk-domain acknowledge; clears pending[i] and overrun[i]
cnt_clr  input  N_CH  clk-domain synchronous clear of count for channel i
edge_pulse  output  N_CH  one-cycle strobe per detected edge
pending  output  N_CH  sticky "edge seen, not yet acknowledged"
overrun  output  N_CH  sticky "edge detected while pending already set"
count  output  N_CH*CNT_W  per-channel saturating edge count, bits [CNT_W*(i+1)-1:CNT_W*i]

Behaviour:
- Async capture, per channel:
  - tog_r toggles on posedge async_sig[i].
  - tog_f toggles on negedge async_sig[i].
  - Both toggles run regardless of edge_mode. reset clears both asynchronously.
- Sync chain:
  - Each toggle feeds its own SYNC_STAGES-deep clk-domain chain, then a history flop prev.
  - Raw detect det_x = sync_last_x XOR prev_x, for x = r, f.
  - prev and sync flops always update, so changing edge_mode never creates a spurious event.
- Mode gating (applied in clk domain):
  - ev_r = det_r AND mode[0]; ev_f = det_f AND mode[1].
  - Mode changes take effect the same cycle.
- edge_pulse[i] = ev_r OR ev_f.
  - Decoded from flops only; glitch-free; high exactly one clk cycle per detect.
- Latency: edge_pulse rises after the SYNC_STAGES-th posedge clk following the async edge, +1 cycle if the edge falls in the clk setup/hold window.
- pending (registered), per posedge:
  - ack=1 and no event: pending <= 0, overrun <= 0.
  - Event, pending=0 or ack=1: pending <= 1; overrun unchanged (ack clears it).
  - Event, pending=1 and ack=0: overrun <= 1.
  - ev_r and ev_f in the same cycle with pending=0 and ack=0: pending <= 1, overrun <= 1 (two events, one flag).
- count (registered):
  - cnt_clr has priority: count <= 0; events that cycle are discarded.
  - Otherwise count <= min(count + ev_r + ev_f, 2^CNT_W - 1).
  - Increment is 0, 1 or 2; saturates, never wraps.
- Reset values: edge_pulse 0, pending 0, overrun 0, count 0; all toggle, sync and prev flops 0.
  - Reset mid-operation discards in-flight edges.
  - An edge arriving during reset is not captured.
- Limitation: same-direction edges on one channel closer than 2 clk periods may cancel in the toggle path and be missed. This is not flagged; callers must guarantee the spacing.
- Channels are fully independent; no cross-channel interaction.

Test Plan:
- Reset, then mode=01 on ch0 with a single 1 ns high pulse on async_sig[0] mid-cycle, SYNC_STAGES=2 -> edge_pulse[0] high exactly 1 cycle after the 2nd posedge; pending[0]=1; count0=1; other channels stay 0.
- Mode=11 on ch1 with a 3-cycle-wide pulse -> two edge_pulse[1] strobes 3 cycles apart; count1=2; overrun[1]=1 because the second edge arrives with pending still set.
- Mode=10 on ch2 with rising then falling edges -> only the falling edge produces a pulse; count2=1. Switch mode to 00 and toggle the input -> no pulses; restore 10 -> no spurious pulse.
- ack[0] asserted in the same cycle as a new ch0 event -> pending[0] stays 1; overrun[0]=0. Next cycle with ack[0]=1 and no event -> pending[0]=0.
- CNT_W=2 with 5 spaced rising edges -> count saturates at 3. Assert cnt_clr together with an event -> count=0.
- Assert reset while an edge is in the synchroniser -> all outputs 0, no pulse after reset deasserts; next edge detected normally.

Source files
------------

// File: rtl/edge_trap_bank.sv
// Multi-channel asynchronous edge trap: toggle capture clocked by each async input,
// synchronised into clk, reported as a strobe, a sticky pending/overrun pair and a saturating count.
module edge_trap_bank #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         async_sig,
    input  logic [2*N_CH-1:0]       edge_mode,
    input  logic [N_CH-1:0]         ack,
    input  logic [N_CH-1:0]         cnt_clr,
    output logic [N_CH-1:0]         edge_pulse,
    output logic [N_CH-1:0]         pending,
    output logic [N_CH-1:0]         overrun,
    output logic [N_CH*CNT_W-1:0]   count
);

    localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_ch
            logic                   tog_r;
            logic                   tog_f;
            logic [SYNC_STAGES-1:0] sync_r;
            logic [SYNC_STAGES-1:0] sync_f;
            logic                   prev_r;
            logic                   prev_f;
            logic                   det_r;
            logic                   det_f;
            logic                   ev_r;
            logic                   ev_f;
            logic                   pend_q;
            logic                   ovr_q;
            logic [CNT_W-1:0]       cnt_q;
            logic [CNT_W+1:0]       cnt_sum;

            // Toggles are clocked by the event itself so even sub-clk pulses flip them.
            always_ff @(posedge async_sig[i] or posedge reset) begin
                if (reset) tog_r <= 1'b0;
                else       tog_r <= ~tog_r;
            end

            always_ff @(negedge async_sig[i] or posedge reset) begin
                if (reset) tog_f <= 1'b0;
                else       tog_f <= ~tog_f;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_r <= '0;
                    sync_f <= '0;
                    prev_r <= 1'b0;
                    prev_f <= 1'b0;
                end else begin
                    sync_r <= {sync_r[SYNC_STAGES-2:0], tog_r};
                    sync_f <= {sync_f[SYNC_STAGES-2:0], tog_f};
                    prev_r <= sync_r[SYNC_STAGES-1];
                    prev_f <= sync_f[SYNC_STAGES-1];
                end
            end

            // Mode gates only the detect, never the history, so mode changes cannot fake an edge.
            assign det_r = sync_r[SYNC_STAGES-1] ^ prev_r;
            assign det_f = sync_f[SYNC_STAGES-1] ^ prev_f;
            assign ev_r  = det_r & edge_mode[2*i];
            assign ev_f  = det_f & edge_mode[2*i+1];

            assign cnt_sum = {2'b00, cnt_q}
                           + {{(CNT_W+1){1'b0}}, ev_r}
                           + {{(CNT_W+1){1'b0}}, ev_f};

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pend_q <= 1'b0;
                    ovr_q  <= 1'b0;
                end else if (ev_r || ev_f) begin
                    if (!pend_q || ack[i]) begin
                        pend_q <= 1'b1;
                        if (ev_r && ev_f && !ack[i]) ovr_q <= 1'b1;
                    end else begin
                        ovr_q <= 1'b1;
                    end
                end else if (ack[i]) begin
                    pend_q <= 1'b0;
                    ovr_q  <= 1'b0;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset)                  cnt_q <= '0;
                else if (cnt_clr[i])        cnt_q <= '0;
                else if (cnt_sum > CNT_MAX) cnt_q <= CNT_MAX[CNT_W-1:0];
                else                        cnt_q <= cnt_sum[CNT_W-1:0];
            end

            assign edge_pulse[i]                = ev_r | ev_f;
            assign pending[i]                   = pend_q;
            assign overrun[i]                   = ovr_q;
            assign count[CNT_W*i +: CNT_W]      = cnt_q;
        end
    endgenerate

endmodule

// File: tb/tb_edge_trap_bank.sv
// Directed bench for edge_trap_bank: default 4-channel instance plus a 1-channel,
// 2-bit-counter instance for saturation.
module tb_edge_trap_bank;

    logic        clk;
    logic        reset;
    logic [3:0]  async_sig;
    logic [7:0]  edge_mode;
    logic [3:0]  ack;
    logic [3:0]  cnt_clr;
    logic [3:0]  edge_pulse;
    logic [3:0]  pending;
    logic [3:0]  overrun;
    logic [31:0] count;

    logic        a2;
    logic [1:0]  m2;
    logic        ack2;
    logic        clr2;
    logic        p2;
    logic        pd2;
    logic        ov2;
    logic [1:0]  c2;

    int n_cmp = 0;
    int n_mis = 0;

    edge_trap_bank dut (
        .clk(clk), .reset(reset), .async_sig(async_sig), .edge_mode(edge_mode),
        .ack(ack), .cnt_clr(cnt_clr), .edge_pulse(edge_pulse), .pending(pending),
        .overrun(overrun), .count(count)
    );

    edge_trap_bank #(.N_CH(1), .SYNC_STAGES(2), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .async_sig(a2), .edge_mode(m2),
        .ack(ack2), .cnt_clr(clr2), .edge_pulse(p2), .pending(pd2),
        .overrun(ov2), .count(c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge: raise the channel, lower it after `width` negedges
    // (width 0 = 1 ns pulse), record edge_pulse[ch] at each of the next 12 negedges.
    task automatic run_pulse(input int ch, input int width, output logic [11:0] obs);
        obs = '0;
        #1 async_sig[ch] = 1'b1;
        if (width == 0) #1 async_sig[ch] = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            obs[j-1] = edge_pulse[ch];
            if (j == width) #1 async_sig[ch] = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({edge_pulse, pending, overrun} !== 12'h000 || count !== 32'h0) begin
            n_mis++;
            $display("FAIL reset_outputs: got pulse=%b pend=%b ovr=%b cnt=%h, want all 0",
                     edge_pulse, pending, overrun, count);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rising_narrow();
        logic [11:0] obs;
        edge_mode[1:0] = 2'b01;
        run_pulse(0, 0, obs);
        n_cmp++;
        if (obs !== 12'b0000_0000_0010) begin
            n_mis++;
            $display("FAIL rise_pulse_timing: got %b, want %b", obs, 12'b0000_0000_0010);
        end
        n_cmp++;
        if (pending !== 4'b0001 || overrun !== 4'b0000) begin
            n_mis++;
            $display("FAIL rise_pending: got pend=%b ovr=%b, want 0001/0000", pending, overrun);
        end
        n_cmp++;
        if (count !== 32'h0000_0001) begin
            n_mis++;
            $display("FAIL rise_count: got %h, want 00000001", count);
        end
    endtask

    task automatic test_both_overrun();
        logic [11:0] obs;
        edge_mode[3:2] = 2'b11;
        run_pulse(1, 3, obs);
        n_cmp++;
        if (obs !== 12'b0000_0001_0010) begin
            n_mis++;
            $display("FAIL both_pulses: got %b, want %b", obs, 12'b0000_0001_0010);
        end
        n_cmp++;
        if (count[15:8] !== 8'd2) begin
            n_mis++;
            $display("FAIL both_count: got %0d, want 2", count[15:8]);
        end
        n_cmp++;
        if (pending[1] !== 1'b1 || overrun[1] !== 1'b1) begin
            n_mis++;
            $display("FAIL both_overrun: got pend=%b ovr=%b, want 1/1", pending[1], overrun[1]);
        end
        ack[1] = 1'b1;
        @(negedge clk);
        ack[1] = 1'b0;
        n_cmp++;
        if (pending[1] !== 1'b0 || overrun[1] !== 1'b0) begin
            n_mis++;
            $display("FAIL ack_clears: got pend=%b ovr=%b, want 0/0", pending[1], overrun[1]);
        end
    endtask

    task automatic test_falling_mode();
        logic [11:0] obs;
        edge_mode[5:4] = 2'b10;
        run_pulse(2, 3, obs);
        n_cmp++;
        if (obs !== 12'b0000_0001_0000) begin
            n_mis++;
            $display("FAIL fall_only: got %b, want %b", obs, 12'b0000_0001_0000);
        end
        n_cmp++;
        if (count[23:16] !== 8'd1) begin
            n_mis++;
            $display("FAIL fall_count: got %0d, want 1", count[23:16]);
        end
        edge_mode[5:4] = 2'b00;
        run_pulse(2, 3, obs);
        n_cmp++;
        if (obs !== 12'b0) begin
            n_mis++;
            $display("FAIL mode_off: got %b, want 0", obs);
        end
        edge_mode[5:4] = 2'b10;
        obs = '0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            obs[j] = edge_pulse[2];
        end
        n_cmp++;
        if (obs !== 12'b0 || count[23:16] !== 8'd1) begin
            n_mis++;
            $display("FAIL mode_restore: got pulses=%b cnt=%0d, want 0/1", obs, count[23:16]);
        end
    endtask

    task automatic test_ack_with_event();
        #1 async_sig[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (edge_pulse[0] !== 1'b1) begin
            n_mis++;
            $display("FAIL ack_evt_pulse: got %b, want 1", edge_pulse[0]);
        end
        ack[0] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (pending[0] !== 1'b1 || overrun[0] !== 1'b0) begin
            n_mis++;
            $display("FAIL ack_evt_same: got pend=%b ovr=%b, want 1/0", pending[0], overrun[0]);
        end
        @(negedge clk);
        n_cmp++;
        if (pending[0] !== 1'b0 || count[7:0] !== 8'd2) begin
            n_mis++;
            $display("FAIL ack_next: got pend=%b cnt=%0d, want 0/2", pending[0], count[7:0]);
        end
        ack[0] = 1'b0;
        #1 async_sig[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_saturate_clear();
        m2 = 2'b01;
        for (int k = 0; k < 5; k++) begin
            #1 a2 = 1'b1;
            repeat (3) @(negedge clk);
            #1 a2 = 1'b0;
            repeat (3) @(negedge clk);
            n_cmp++;
            if (c2 !== ((k + 1 > 3) ? 2'd3 : 2'(k + 1))) begin
                n_mis++;
                $display("FAIL sat_count_%0d: got %0d, want %0d", k, c2, (k + 1 > 3) ? 3 : k + 1);
            end
        end
        #1 a2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (p2 !== 1'b1) begin
            n_mis++;
            $display("FAIL clr_evt_pulse: got %b, want 1", p2);
        end
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        n_cmp++;
        if (c2 !== 2'd0) begin
            n_mis++;
            $display("FAIL clr_priority: got %0d, want 0", c2);
        end
        #1 a2 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_inflight();
        logic [11:0] obs;
        edge_mode[7:6] = 2'b01;
        #1 async_sig[3] = 1'b1;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({edge_pulse, pending, overrun} !== 12'h000 || count !== 32'h0) begin
            n_mis++;
            $display("FAIL midreset_outputs: got pulse=%b pend=%b ovr=%b cnt=%h, want all 0",
                     edge_pulse, pending, overrun, count);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        obs = '0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            obs[j] = edge_pulse[3];
        end
        n_cmp++;
        if (obs !== 12'b0) begin
            n_mis++;
            $display("FAIL midreset_no_pulse: got %b, want 0", obs);
        end
        #1 async_sig[3] = 1'b0;
        repeat (3) @(negedge clk);
        run_pulse(3, 2, obs);
        n_cmp++;
        if (obs !== 12'b0000_0000_0010 || count[31:24] !== 8'd1 || pending !== 4'b1000) begin
            n_mis++;
            $display("FAIL post_reset_edge: got pulses=%b cnt=%0d pend=%b, want %b/1/1000",
                     obs, count[31:24], pending, 12'b0000_0000_0010);
        end
    endtask

    initial begin
        reset = 1'b1;
        async_sig = '0;
        edge_mode = '0;
        ack = '0;
        cnt_clr = '0;
        a2 = 1'b0;
        m2 = 2'b00;
        ack2 = 1'b0;
        clr2 = 1'b0;
        test_reset();
        test_rising_narrow();
        test_both_overrun();
        test_falling_mode();
        test_ack_with_event();
        test_saturate_clear();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
